crtc_timing_gen: RTL
====================

// Module: crtc_timing_gen
// PURPOSE
//  Parametrised 6845-class CRT controller. Successor to the fixed-width MC6845 core.
//  Generates HSYNC/VSYNC/DE, memory address MA and raster address RA from a programmable
//  register file, written through the 6845-style CSn/E/RS/RW host bus.
//  Adds over the MC6845 core:
//   - generic counter widths; a single clock with a character-clock enable
//   - programmable sync/DE polarity; a blinking cursor output
// PARAMETERS
//  HW     8   horizontal char counter width (R0,R1,R2)
//  VW     7   character-row counter width (R4,R6,R7)
//  RAW    5   raster (scanline) counter width (R5,R9,R10,R11)
//  MAW    14  memory address width (R12-R15)
// PORTS
//  CLK     in   1    system clock, all logic on posedge
//  RST     in   1    synchronous, active-high reset
//  CCLK_EN in   1    character-clock enable; display counters advance only when high
//  CSn     in   1    chip select, active low
//  E       in   1    bus strobe, sampled on CLK; access commits on sampled falling edge
//  RS      in   1    0 = address register, 1 = data register
//  RW      in   1    0 = write, 1 = read
//  D_IN    in   8    host write data
//  D_OUT   out  8    host read data
//  D_OE    out  1    high while CSn=0, RW=1, E=1 (tristate enable for top level)
//  HSYNC   out  1    horizontal sync (polarity per R16[0])
//  VSYNC   out  1    vertical sync (polarity per R16[1])
//  DE      out  1    display enable (polarity per R16[2])
//  MA      out  MAW  refresh memory address
//  RA      out  RAW  raster address within character row
//  CURSOR  out  1    cursor active, qualified by DE and blink
// BEHAVIOUR
//  Reset:
//   - all registers, counters, frame counter and address pointer clear to 0
//   - D_OUT=0, D_OE=0, MA=0, RA=0, CURSOR=0; HSYNC/VSYNC/DE=0 (polarity bits reset to 0)
//  Host bus:
//   - e_q = E delayed one CLK; access commits when e_q=1 && E=0 && CSn=0
//   - write, RS=0: addr <= D_IN[4:0]; write, RS=1: R[addr] <= D_IN, truncated to field width
//   - addresses >16 ignored on write
//   - read: D_OUT is combinational from addr
//     - R14/R15 and R16 return their values, zero-extended
//     - all other addresses return 0; address register itself is not readable
//  Register map:
//   R0 Htotal-1; R1 Hdisp; R2 Hsync pos
//   R3 [3:0] Hsync width, [7:4] Vsync width in scanlines (0 means 16)
//   R4 Vtotal-1 (rows); R5 Vadjust scanlines; R6 Vdisp rows; R7 Vsync row; R9 max raster
//   R10 [4:0] cursor start, [6:5] blink mode; R11 cursor end
//   R12/R13 start address hi/lo; R14/R15 cursor address hi/lo
//   R16 [2:0] DE/VS/HS invert; R8 stored, no effect
//  Counters (update only on CLK edges with CCLK_EN=1):
//   - hcnt: wraps to 0 when hcnt>=R0; >= also recovers if R0 is lowered mid-line
//   - on hcnt wrap, ra increments; ra wraps when ra>=R9
//   - on ra wrap, row increments and row_base <= row_base+R1
//   - when row>=R4 and ra wraps, enter ADJUST for R5 scanlines (skip if R5=0)
//   - end of frame: row=0, ra=0, row_base <= {R12,R13}, frame_cnt++
//   - MA = row_base + hcnt, modulo 2^MAW
//  Frame state machine: ACTIVE_ROWS -> ADJUST -> ACTIVE_ROWS (ADJUST bypassed if R5=0)
//  Sync and display:
//   - DE = (hcnt<R1) && (row<R6) && state!=ADJUST
//   - HSYNC rises when hcnt==R2; held R3[3:0] chars (0 means 16); truncated by hcnt wrap
//   - VSYNC rises at hcnt==0, ra==0, row==R7, state!=ADJUST; held R3[7:4] scanlines (0 means 16)
//   - VSYNC may span the frame boundary
//   - CURSOR = DE && MA=={R14,R15} && R10[4:0]<=RA<=R11 && blink_on
//     - blink_on by R10[6:5]: 00 on, 01 off, 10 frame_cnt[3], 11 frame_cnt[4]
//  Timing and boundary cases:
//   - outputs are registered: valid on the CLK edge after the enabling CCLK_EN cycle
//   - write and CCLK_EN in same cycle: counters use the pre-write register value
//   - RST mid-frame: all state returns to reset values on the same edge; registers must be reprogrammed
//   - CCLK_EN=0: all display outputs hold
// TESTING
//  1. Write addr 14, data 0x3A; addr 15, data 0xAD; read both -> 0x3A, 0xAD. Read R0 -> 0x00.
//  2. R0=9, R1=6, R2=7, R3=0x22, CCLK_EN=1:
//     - DE high for hcnt 0..5; HSYNC high for hcnt 7,8; line length 10 enables.
//  3. R4=3, R5=2, R6=2, R7=3, R9=1:
//     - frame = 4*2+2 = 10 scanlines; VSYNC rises at row 3, ra 0, lasts 2 scanlines;
//     - DE off in rows 2-3 and ADJUST.
//  4. R12/R13=0x0100, R1=6:
//     - MA = 0x100..0x105 on row 0, 0x106.. on row 1; reloads 0x100 next frame.
//     - With MAW=14, start 0x3FFE wraps MA to 0x0000.
//  5. Cursor {R14,R15}=0x102, R10=0x41, R11=1 (blink 1/16):
//     - CURSOR at MA 0x102, RA 1 only; toggles every 8 frames.
//  6. R16=7 -> HSYNC/VSYNC/DE idle high. RST mid-line -> all outputs 0, MA=0 next edge.

Source files
------------

// File: rtl/crtc_timing_gen.sv
// 6845-class CRT timing generator with a 6845-style host bus, programmable
// counter widths, sync/DE polarity and a blinking cursor.
// Display outputs are registered; on each enabled character clock they
// present the decode of the character position held by the counters at that edge.
module crtc_timing_gen #(
    parameter int HW  = 8,
    parameter int VW  = 7,
    parameter int RAW = 5,
    parameter int MAW = 14
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CCLK_EN,
    input  logic           CSn,
    input  logic           E,
    input  logic           RS,
    input  logic           RW,
    input  logic [7:0]     D_IN,
    output logic [7:0]     D_OUT,
    output logic           D_OE,
    output logic           HSYNC,
    output logic           VSYNC,
    output logic           DE,
    output logic [MAW-1:0] MA,
    output logic [RAW-1:0] RA,
    output logic           CURSOR
);

    typedef enum logic {ST_ACTIVE, ST_ADJUST} state_t;

    // register file
    logic [4:0]     addr;
    logic           e_q;
    logic [HW-1:0]  r_htot, r_hdisp, r_hsync;
    logic [7:0]     r_sync_w;
    logic [VW-1:0]  r_vtot, r_vdisp, r_vsync;
    logic [RAW-1:0] r_vadj, r_maxra, r_cstart, r_cend;
    logic [1:0]     r_blink;
    logic [7:0]     r8_unused;
    logic [MAW-9:0] r_start_hi, r_cur_hi;
    logic [7:0]     r_start_lo, r_cur_lo;
    logic [2:0]     r_inv;

    // display counters
    state_t         state, state_nxt;
    logic [HW-1:0]  hcnt, hcnt_nxt;
    logic [RAW-1:0] ra, ra_nxt;
    logic [VW-1:0]  row, row_nxt;
    logic [MAW-1:0] row_base, base_nxt;
    logic [4:0]     frame_cnt, frame_nxt;
    logic           eof;

    // sync run state: *_rem counts units left including the current one
    logic           hs_run, vs_run;
    logic [4:0]     hs_rem, vs_rem;

    logic commit;
    assign commit = e_q && !E && !CSn;
    assign D_OE   = !CSn && RW && E;

    // host bus: E falling edge commits address or data writes
    always_ff @(posedge CLK) begin
        if (RST) begin
            e_q <= 1'b0; addr <= '0;
            r_htot <= '0; r_hdisp <= '0; r_hsync <= '0; r_sync_w <= '0;
            r_vtot <= '0; r_vadj <= '0; r_vdisp <= '0; r_vsync <= '0;
            r8_unused <= '0; r_maxra <= '0; r_cstart <= '0; r_blink <= '0;
            r_cend <= '0; r_start_hi <= '0; r_start_lo <= '0;
            r_cur_hi <= '0; r_cur_lo <= '0; r_inv <= '0;
        end else begin
            e_q <= E;
            if (commit && !RW) begin
                if (!RS) begin
                    addr <= D_IN[4:0];
                end else begin
                    case (addr)
                        5'd0:  r_htot     <= D_IN[HW-1:0];
                        5'd1:  r_hdisp    <= D_IN[HW-1:0];
                        5'd2:  r_hsync    <= D_IN[HW-1:0];
                        5'd3:  r_sync_w   <= D_IN;
                        5'd4:  r_vtot     <= D_IN[VW-1:0];
                        5'd5:  r_vadj     <= D_IN[RAW-1:0];
                        5'd6:  r_vdisp    <= D_IN[VW-1:0];
                        5'd7:  r_vsync    <= D_IN[VW-1:0];
                        5'd8:  r8_unused  <= D_IN;
                        5'd9:  r_maxra    <= D_IN[RAW-1:0];
                        5'd10: begin
                            r_cstart <= D_IN[RAW-1:0];
                            r_blink  <= D_IN[6:5];
                        end
                        5'd11: r_cend     <= D_IN[RAW-1:0];
                        5'd12: r_start_hi <= D_IN[MAW-9:0];
                        5'd13: r_start_lo <= D_IN;
                        5'd14: r_cur_hi   <= D_IN[MAW-9:0];
                        5'd15: r_cur_lo   <= D_IN;
                        5'd16: r_inv      <= D_IN[2:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // read mux: only cursor address and polarity are readable
    always_comb begin
        D_OUT = 8'h00;
        case (addr)
            5'd14: D_OUT = {{(16-MAW){1'b0}}, r_cur_hi};
            5'd15: D_OUT = r_cur_lo;
            5'd16: D_OUT = {5'b00000, r_inv};
            default: D_OUT = 8'h00;
        endcase
    end

    logic h_wrap, ra_wrap, v_last, adj_done;
    assign h_wrap   = hcnt >= r_htot;
    assign ra_wrap  = ra >= r_maxra;
    assign v_last   = row >= r_vtot;
    assign adj_done = ({1'b0, ra} + (RAW+1)'(1)) >= {1'b0, r_vadj};

    // frame sequencing: next counter values and ACTIVE/ADJUST transitions
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt + HW'(1);
        ra_nxt    = ra;
        row_nxt   = row;
        base_nxt  = row_base;
        frame_nxt = frame_cnt;
        eof       = 1'b0;
        if (h_wrap) begin
            hcnt_nxt = '0;
            ra_nxt   = ra + RAW'(1);
            case (state)
                ST_ACTIVE: begin
                    if (ra_wrap) begin
                        ra_nxt   = '0;
                        row_nxt  = row + VW'(1);
                        base_nxt = row_base + MAW'(r_hdisp);
                        if (v_last) begin
                            if (r_vadj == '0) eof = 1'b1;
                            else              state_nxt = ST_ADJUST;
                        end
                    end
                end
                ST_ADJUST: begin
                    if (adj_done) eof = 1'b1;
                end
                default: state_nxt = ST_ACTIVE;
            endcase
            if (eof) begin
                state_nxt = ST_ACTIVE;
                ra_nxt    = '0;
                row_nxt   = '0;
                base_nxt  = {r_start_hi, r_start_lo};
                frame_nxt = frame_cnt + 5'd1;
            end
        end
    end

    // state and counter registers, advanced by the character clock
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_ACTIVE; hcnt <= '0; ra <= '0; row <= '0;
            row_base <= '0; frame_cnt <= '0;
        end else if (CCLK_EN) begin
            state <= state_nxt; hcnt <= hcnt_nxt; ra <= ra_nxt; row <= row_nxt;
            row_base <= base_nxt; frame_cnt <= frame_nxt;
        end
    end

    logic       hs_start, vs_start, hs_on, vs_on;
    logic [4:0] hs_w, vs_w, hs_left, vs_left;
    assign hs_start = hcnt == r_hsync;
    assign vs_start = (hcnt == '0) && (ra == '0) && (row == r_vsync) && (state == ST_ACTIVE);
    assign hs_w     = (r_sync_w[3:0] == 4'd0) ? 5'd16 : {1'b0, r_sync_w[3:0]};
    assign vs_w     = (r_sync_w[7:4] == 4'd0) ? 5'd16 : {1'b0, r_sync_w[7:4]};
    assign hs_left  = hs_start ? hs_w : hs_rem;
    assign vs_left  = vs_start ? vs_w : vs_rem;
    assign hs_on    = hs_start || hs_run;
    assign vs_on    = vs_start || vs_run;

    // sync stretchers: HSYNC counts chars and dies at line end, VSYNC counts scanlines
    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_run <= 1'b0; hs_rem <= '0; vs_run <= 1'b0; vs_rem <= '0;
        end else if (CCLK_EN) begin
            hs_rem <= hs_left - 5'd1;
            hs_run <= !h_wrap && hs_on && (hs_left > 5'd1);
            if (h_wrap) begin
                vs_rem <= vs_left - 5'd1;
                vs_run <= vs_on && (vs_left > 5'd1);
            end else begin
                vs_rem <= vs_left;
                vs_run <= vs_on;
            end
        end
    end

    logic           de_raw, blink_on, cur_hit;
    logic [MAW-1:0] ma_cur;
    assign de_raw = (hcnt < r_hdisp) && (row < r_vdisp) && (state != ST_ADJUST);
    assign ma_cur = row_base + MAW'(hcnt);

    // blink source selection
    always_comb begin
        blink_on = 1'b1;
        case (r_blink)
            2'b00: blink_on = 1'b1;
            2'b01: blink_on = 1'b0;
            2'b10: blink_on = frame_cnt[3];
            2'b11: blink_on = frame_cnt[4];
            default: blink_on = 1'b1;
        endcase
    end

    assign cur_hit = de_raw && (ma_cur == {r_cur_hi, r_cur_lo}) &&
                     (ra >= r_cstart) && (ra <= r_cend) && blink_on;

    // registered display outputs; hold while the character clock is idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            HSYNC <= 1'b0; VSYNC <= 1'b0; DE <= 1'b0;
            MA <= '0; RA <= '0; CURSOR <= 1'b0;
        end else if (CCLK_EN) begin
            HSYNC  <= hs_on ^ r_inv[0];
            VSYNC  <= vs_on ^ r_inv[1];
            DE     <= de_raw ^ r_inv[2];
            MA     <= ma_cur;
            RA     <= ra;
            CURSOR <= cur_hit;
        end
    end

endmodule
